// File: rtl/rob_pkg.sv
// Reorder buffer shared types: register widths and entry layout.
// Imported by rob_if, rob_ptr and rob.
package rob_pkg;

  localparam int AREG_W = 5;
  localparam int PREG_W = 6;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              reg_write;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] new_preg;
    logic [PREG_W-1:0] old_preg;
  } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// Reorder buffer bundle: allocate, complete, retire and occupancy.
// master = rename/execute side, slave = ROB side.
interface rob_if #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
);
  import rob_pkg::*;

  logic              alloc_valid;
  logic              alloc_ready;
  logic [AREG_W-1:0] alloc_rd;
  logic              alloc_reg_write;
  logic [PREG_W-1:0] alloc_new_preg;
  logic [PREG_W-1:0] alloc_old_preg;
  logic [IDX_W-1:0]  alloc_idx;

  logic              cmpl_valid;
  logic [IDX_W-1:0]  cmpl_idx;

  logic              retire_valid;
  logic [AREG_W-1:0] retire_rd;
  logic [PREG_W-1:0] retire_new_preg;
  logic              retire_free_valid;
  logic [PREG_W-1:0] retire_free_preg;

  logic [IDX_W:0]    count;

  modport master (
    output alloc_valid, alloc_rd, alloc_reg_write,
    output alloc_new_preg, alloc_old_preg,
    output cmpl_valid, cmpl_idx,
    input  alloc_ready, alloc_idx,
    input  retire_valid, retire_rd, retire_new_preg,
    input  retire_free_valid, retire_free_preg,
    input  count
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_reg_write,
    input  alloc_new_preg, alloc_old_preg,
    input  cmpl_valid, cmpl_idx,
    output alloc_ready, alloc_idx,
    output retire_valid, retire_rd, retire_new_preg,
    output retire_free_valid, retire_free_preg,
    output count
  );

endinterface

// File: rtl/rob_ptr.sv
// Wrapping circular-buffer pointer; MSB is the wrap bit.
// Increment enable plus synchronous clear.
module rob_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order retire of renamed instructions, frees old pregs.
// Optional ROB_FLUSH_EN adds a synchronous flush input.
module rob
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ROB_FLUSH_EN
  input  logic flush,
`endif
  rob_if.slave io
);

  logic [IDX_W:0]   head_ptr, tail_ptr;
  logic [IDX_W-1:0] head_idx, tail_idx;
  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  rob_entry_t       head_e;
  logic             full, clr, retire, alloc_fire;

`ifdef ROB_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign head_idx = head_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];
  assign full     = (head_idx == tail_idx) &&
                    (head_ptr[IDX_W] != tail_ptr[IDX_W]);
  assign head_e   = ent_q[head_idx];

  // done is registered, so a head completion retires a cycle later
  assign retire     = head_e.valid && head_e.done && !clr;
  assign alloc_fire = io.alloc_valid && !full && !clr;

  rob_ptr #(.W(IDX_W+1)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .inc_i (retire),
    .ptr_o (head_ptr)
  );

  rob_ptr #(.W(IDX_W+1)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .inc_i (alloc_fire),
    .ptr_o (tail_ptr)
  );

  always_comb begin
    ent_d = ent_q;
    if (io.cmpl_valid && ent_q[io.cmpl_idx].valid)
      ent_d[io.cmpl_idx].done = 1'b1;
    if (retire) begin
      ent_d[head_idx].valid = 1'b0;
      ent_d[head_idx].done  = 1'b0;
    end
    if (alloc_fire) begin
      ent_d[tail_idx].valid     = 1'b1;
      ent_d[tail_idx].done      = 1'b0;
      ent_d[tail_idx].reg_write = io.alloc_reg_write;
      ent_d[tail_idx].rd        = io.alloc_rd;
      ent_d[tail_idx].new_preg  = io.alloc_new_preg;
      ent_d[tail_idx].old_preg  = io.alloc_old_preg;
    end
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].done  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
    end
  end

  assign io.alloc_ready = !full;
  assign io.alloc_idx   = tail_idx;
  assign io.count       = tail_ptr - head_ptr;

  assign io.retire_valid    = retire;
  assign io.retire_rd       = retire ? head_e.rd       : '0;
  assign io.retire_new_preg = retire ? head_e.new_preg : '0;

  // preg 0 is the hardwired zero mapping and never re-enters the free list
  assign io.retire_free_valid = retire && head_e.reg_write &&
                                (head_e.old_preg != '0);
  assign io.retire_free_preg  = retire ? head_e.old_preg : '0;

endmodule

// File: tb/tb_rob.sv
// Directed-vector bench for rob (DEPTH=16).
// Flush vectors compile only with ROB_FLUSH_EN.
module tb_rob;
  import rob_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rob_if #(.DEPTH(DEPTH)) bus ();

`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
`endif

  rob #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef ROB_FLUSH_EN
    .flush (flush),
`endif
    .io    (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid     = 1'b0;
    bus.alloc_rd        = '0;
    bus.alloc_reg_write = 1'b0;
    bus.alloc_new_preg  = '0;
    bus.alloc_old_preg  = '0;
    bus.cmpl_valid      = 1'b0;
    bus.cmpl_idx        = '0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic rw,
                       input logic [5:0] np, input logic [5:0] op);
    bus.alloc_valid     = 1'b1;
    bus.alloc_rd        = rd;
    bus.alloc_reg_write = rw;
    bus.alloc_new_preg  = np;
    bus.alloc_old_preg  = op;
    tick();
    bus.alloc_valid     = 1'b0;
  endtask

  task automatic cmpl(input logic [3:0] idx);
    bus.cmpl_valid = 1'b1;
    bus.cmpl_idx   = idx;
    tick();
    bus.cmpl_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    #1;
    check("rst_count", 32'(bus.count), 0);
    check("rst_rv", 32'(bus.retire_valid), 0);
    check("rst_fv", 32'(bus.retire_free_valid), 0);
    check("rst_ready", 32'(bus.alloc_ready), 1);
    check("rst_idx", 32'(bus.alloc_idx), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single allocate / complete / retire
    check("t1_idx", 32'(bus.alloc_idx), 0);
    alloc(5'd3, 1'b1, 6'd33, 6'd3);
    check("t1_cnt1", 32'(bus.count), 1);
    check("t1_rv0", 32'(bus.retire_valid), 0);
    check("t1_rd0", 32'(bus.retire_rd), 0);
    cmpl(4'd0);
    check("t1_rv", 32'(bus.retire_valid), 1);
    check("t1_rd", 32'(bus.retire_rd), 3);
    check("t1_new", 32'(bus.retire_new_preg), 33);
    check("t1_fv", 32'(bus.retire_free_valid), 1);
    check("t1_free", 32'(bus.retire_free_preg), 3);
    check("t1_cntr", 32'(bus.count), 1);
    tick();
    check("t1_cnt0", 32'(bus.count), 0);
    check("t1_rvend", 32'(bus.retire_valid), 0);

    // fill to full, blocked alloc, retire one, alloc+retire together
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      alloc(5'(i), 1'b1, 6'(16 + i), 6'(i + 1));
    check("t2_ready", 32'(bus.alloc_ready), 0);
    check("t2_cnt", 32'(bus.count), 16);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd31;
    tick();
    bus.alloc_valid = 1'b0;
    check("t2_blk", 32'(bus.count), 16);
    cmpl(4'd0);
    check("t2_rv", 32'(bus.retire_valid), 1);
    check("t2_new", 32'(bus.retire_new_preg), 16);
    check("t2_rdy_r", 32'(bus.alloc_ready), 0);
    tick();
    check("t2_cnt15", 32'(bus.count), 15);
    check("t2_rdy1", 32'(bus.alloc_ready), 1);
    check("t2_rv0", 32'(bus.retire_valid), 0);
    cmpl(4'd1);
    check("t2_rv1", 32'(bus.retire_valid), 1);
    check("t2_rd1", 32'(bus.retire_rd), 1);
    check("t2_aidx", 32'(bus.alloc_idx), 0);
    alloc(5'd20, 1'b1, 6'd50, 6'd7);
    check("t2_same", 32'(bus.count), 15);

    // out-of-order completion, in-order retire
    do_reset();
    alloc(5'd5, 1'b1, 6'd40, 6'd5);
    alloc(5'd6, 1'b1, 6'd41, 6'd6);
    alloc(5'd7, 1'b1, 6'd42, 6'd7);
    cmpl(4'd2);
    check("t3_rv_a", 32'(bus.retire_valid), 0);
    cmpl(4'd1);
    check("t3_rv_b", 32'(bus.retire_valid), 0);
    cmpl(4'd0);
    check("t3_rd0", 32'(bus.retire_rd), 5);
    tick();
    check("t3_rd1", 32'(bus.retire_rd), 6);
    tick();
    check("t3_rd2", 32'(bus.retire_rd), 7);
    check("t3_rv2", 32'(bus.retire_valid), 1);
    tick();
    check("t3_end", 32'(bus.retire_valid), 0);
    check("t3_cnt", 32'(bus.count), 0);

    // no free for old_preg 0 or reg_write 0; stale completion ignored
    do_reset();
    alloc(5'd8, 1'b1, 6'd40, 6'd0);
    alloc(5'd9, 1'b0, 6'd41, 6'd12);
    cmpl(4'd0);
    check("t4_rv0", 32'(bus.retire_valid), 1);
    check("t4_fv0", 32'(bus.retire_free_valid), 0);
    check("t4_rd0", 32'(bus.retire_rd), 8);
    cmpl(4'd1);
    check("t4_rv1", 32'(bus.retire_valid), 1);
    check("t4_fv1", 32'(bus.retire_free_valid), 0);
    check("t4_rd1", 32'(bus.retire_rd), 9);
    check("t4_fp1", 32'(bus.retire_free_preg), 12);
    tick();
    check("t4_cnt", 32'(bus.count), 0);
    cmpl(4'd2);
    alloc(5'd10, 1'b1, 6'd42, 6'd13);
    check("t4_stale", 32'(bus.retire_valid), 0);
    check("t4_cnt1", 32'(bus.count), 1);
    cmpl(4'd2);
    check("t4_rv2", 32'(bus.retire_valid), 1);
    check("t4_fv2", 32'(bus.retire_free_valid), 1);
    check("t4_fp2", 32'(bus.retire_free_preg), 13);
    tick();

    // 40 alloc/retire pairs, pointers wrap twice
    do_reset();
    for (int i = 0; i < 40; i++) begin
      check("t5_aidx", 32'(bus.alloc_idx), 32'(i % 16));
      alloc(5'(i % 32), 1'b1, 6'(i % 64), 6'((i % 63) + 1));
      cmpl(4'(i % 16));
      check("t5_rv", 32'(bus.retire_valid), 1);
      check("t5_rd", 32'(bus.retire_rd), 32'(i % 32));
      check("t5_free", 32'(bus.retire_free_preg), 32'((i % 63) + 1));
      tick();
      check("t5_once", 32'(bus.retire_valid), 0);
    end
    check("t5_cnt", 32'(bus.count), 0);
    check("t5_idx", 32'(bus.alloc_idx), 8);

    // async reset with live entries
    do_reset();
    for (int i = 0; i < 5; i++)
      alloc(5'(i + 1), 1'b1, 6'(40 + i), 6'(i + 1));
    cmpl(4'd1);
    cmpl(4'd2);
    cmpl(4'd3);
    check("t6_pre_rv", 32'(bus.retire_valid), 0);
    check("t6_pre_cnt", 32'(bus.count), 5);
    rst_n = 1'b0;
    #1;
    check("t6_cnt", 32'(bus.count), 0);
    check("t6_rv", 32'(bus.retire_valid), 0);
    check("t6_fv", 32'(bus.retire_free_valid), 0);
    check("t6_rdy", 32'(bus.alloc_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    alloc(5'd11, 1'b1, 6'd50, 6'd21);
    alloc(5'd12, 1'b1, 6'd51, 6'd22);
    cmpl(4'd0);
    check("t6_rv_a", 32'(bus.retire_valid), 1);
    check("t6_rd_a", 32'(bus.retire_rd), 11);
    tick();
    check("t6_donecl", 32'(bus.retire_valid), 0);
    check("t6_cnt1", 32'(bus.count), 1);

`ifdef ROB_FLUSH_EN
    do_reset();
    for (int i = 0; i < 5; i++)
      alloc(5'(i + 1), 1'b1, 6'(40 + i), 6'(i + 1));
    cmpl(4'd0);
    flush = 1'b1;
    bus.alloc_valid = 1'b1;
    #1;
    check("fl_rv", 32'(bus.retire_valid), 0);
    check("fl_fv", 32'(bus.retire_free_valid), 0);
    tick();
    flush = 1'b0;
    bus.alloc_valid = 1'b0;
    check("fl_cnt", 32'(bus.count), 0);
    check("fl_idx", 32'(bus.alloc_idx), 0);
    tick();
    check("fl_rv2", 32'(bus.retire_valid), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, 4..64.
REQ-002 Parameter IDX_W, default $clog2(DEPTH), entry index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 alloc_valid  input  1  rename stage presents one renamed instruction.
REQ-006 alloc_ready  output  1  entry available; allocation occurs on alloc_valid && alloc_ready.
REQ-007 alloc_rd  input  5  architectural destination register.
REQ-008 alloc_reg_write  input  1  instruction writes a destination.
REQ-009 alloc_new_preg  input  6  physical register newly mapped to rd.
REQ-010 alloc_old_preg  input  6  physical register previously mapped to rd.
REQ-011 alloc_idx  output  IDX_W  index assigned to the current allocation (tail).
REQ-012 cmpl_valid  input  1  execution completion strobe.
REQ-013 cmpl_idx  input  IDX_W  index of the completing entry.
REQ-014 retire_valid  output  1  head entry retires this cycle.
REQ-015 retire_rd  output  5  retiring architectural register.
REQ-016 retire_new_preg  output  6  retiring committed mapping, for the retirement alias table.
REQ-017 retire_free_valid  output  1  retire_free_preg returns to the free list this cycle.
REQ-018 retire_free_preg  output  6  physical register being freed.
REQ-019 count  output  IDX_W+1  occupied entries.

Function
REQ-020 Circular buffer; head/tail pointers IDX_W+1 bits with wrap bit; empty = pointers equal, full = indices equal and wrap bits differ.
REQ-021 alloc_ready = !full, from registered state only; no allocation when full even if an entry retires the same cycle.
REQ-022 On allocation, entry[tail] captures rd, reg_write, new_preg, old_preg, valid=1, done=0; tail increments next edge.
REQ-023 alloc_idx = tail index, combinational, valid whenever alloc_ready.
REQ-024 Completion sets done on entry[cmpl_idx] next edge; ignored when the entry is not valid; duplicate completion harmless.
REQ-025 retire_valid = entry[head].valid && entry[head].done, combinational; no backpressure; at most one retire per cycle; head increments and valid clears next edge.
REQ-026 Completion of the head entry retires no earlier than the following cycle.
REQ-027 retire_free_valid = retire_valid && reg_write && old_preg != 0; physical register 0 is never freed.
REQ-028 retire_rd/retire_new_preg/retire_free_preg show head contents; when retire_valid is 0 they are 0.
REQ-029 Simultaneous allocate and retire: count unchanged; allocate into an empty ROB and retire cannot coincide for the same entry.
REQ-030 Pointers wrap from DEPTH-1 to 0, toggling wrap bit; count = tail - head modulo 2*DEPTH.
REQ-031 Retirement strictly in allocation order regardless of completion order.

Reset
REQ-032 rst_n low immediately clears head, tail, all valid and done bits; count=0, retire_valid=0, retire_free_valid=0, alloc_ready=1, alloc_idx=0.
REQ-033 Reset mid-operation discards all entries without issuing any retire or free.
REQ-034 Entry payload fields need no reset.

Configuration
REQ-035 Macro ROB_FLUSH_EN: when defined, adds input flush (1 bit); flush high clears all valid/done and pointers to 0 on next edge, forces retire_valid and retire_free_valid to 0 that cycle, and drops any coincident allocation and completion.
REQ-036 Without ROB_FLUSH_EN: no flush port, no flush logic, behaviour as REQ-020..031.

Structure
REQ-037 Package rob_pkg holds AREG_W=5, PREG_W=6 and typedef rob_entry_t {valid, done, reg_write, rd, new_preg, old_preg}.
REQ-038 One sub-module rob_ptr: IDX_W+1 bit wrapping pointer with increment enable and synchronous clear, instanced for head and tail.

Verification
REQ-039 Reset, allocate rd=3 new=33 old=3, complete idx 0 -> retire_valid next cycle, retire_rd=3, retire_new_preg=33, retire_free_preg=3, count 1->0.
REQ-040 Allocate 16 entries with no completion -> alloc_ready=0 and count=16; completing idx 0 -> one retire, alloc_ready=1 one cycle later.
REQ-041 Allocate idx 0,1,2; complete 2 then 1 then 0 -> retires in order 0,1,2 on consecutive cycles after idx 0 completes.
REQ-042 Allocate old_preg=0 and reg_write=0 entries, complete -> retire_valid=1, retire_free_valid=0 for both.
REQ-043 Run 40 allocate/retire pairs -> pointers wrap twice, alloc_idx sequence 0..15,0..15,0..7, no lost or duplicated retire.
REQ-044 rst_n asserted with 5 entries live, 3 done -> no retire, count=0 at once; with ROB_FLUSH_EN, flush pulse gives same result synchronously.
